// File: rtl/reg_readout_fsm_if.sv
// Handshake and datapath bundle for reg_readout_fsm: sweep request, register-file
// read port and the valid/ready output stream.
interface reg_readout_fsm_if #(
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [3:0]        first_reg;
  logic [3:0]        last_reg;
  logic [DATA_W-1:0] RegData;
  logic              out_ready;
  logic [3:0]        MuxControlA;
  logic [15:0]       RegEnable;
  logic [DATA_W-1:0] out_data;
  logic [3:0]        out_index;
  logic              out_valid;
  logic              busy;
  logic              done;
  logic              chk_err;

  modport master (
    output start, first_reg, last_reg, RegData, out_ready,
    input  MuxControlA, RegEnable, out_data, out_index, out_valid, busy, done, chk_err
  );

  modport slave (
    input  start, first_reg, last_reg, RegData, out_ready,
    output MuxControlA, RegEnable, out_data, out_index, out_valid, busy, done, chk_err
  );
endinterface

// File: rtl/reg_readout_fsm.sv
// Sweeps register indices first_reg..last_reg (wrapping mod 16) and streams each word out.
// Optional Fibonacci sequence check enabled by defining READOUT_FIB_CHECK_EN.
module reg_readout_fsm #(
  parameter int unsigned DATA_W = 16
) (
  input logic              clk,
  input logic              reset,
  reg_readout_fsm_if.slave rf
);

  typedef enum logic [2:0] {StIdle, StSelect, StCapture, StPresent, StDone} state_e;

  state_e            state_q;
  logic [3:0]        idx_q;
  logic [3:0]        end_q;
  logic [3:0]        mux_q;
  logic [DATA_W-1:0] out_data_q;
  logic [3:0]        out_index_q;
  logic              out_valid_q;
  logic              busy_q;
  logic              done_q;

`ifdef READOUT_FIB_CHECK_EN
  logic [DATA_W-1:0] prev1_q;
  logic [DATA_W-1:0] prev2_q;
  logic [1:0]        hist_cnt_q;
  logic              chk_err_q;
  logic [DATA_W-1:0] fib_sum;

  assign fib_sum = prev1_q + prev2_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      end_q       <= '0;
      mux_q       <= '0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef READOUT_FIB_CHECK_EN
      prev1_q     <= '0;
      prev2_q     <= '0;
      hist_cnt_q  <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rf.start) begin
            idx_q   <= rf.first_reg;
            end_q   <= rf.last_reg;
            mux_q   <= rf.first_reg;
            busy_q  <= 1'b1;
            state_q <= StSelect;
`ifdef READOUT_FIB_CHECK_EN
            hist_cnt_q <= '0;
            chk_err_q  <= 1'b0;
`endif
          end
        end
        // Mux A settles for one cycle before RegData is trusted.
        StSelect: state_q <= StCapture;
        StCapture: begin
          out_data_q  <= rf.RegData;
          out_index_q <= idx_q;
          out_valid_q <= 1'b1;
          state_q     <= StPresent;
`ifdef READOUT_FIB_CHECK_EN
          if (hist_cnt_q == 2'd2 && rf.RegData != fib_sum) chk_err_q <= 1'b1;
          if (hist_cnt_q != 2'd2) hist_cnt_q <= hist_cnt_q + 2'd1;
          prev2_q <= prev1_q;
          prev1_q <= rf.RegData;
`endif
        end
        StPresent: begin
          if (rf.out_ready) begin
            out_valid_q <= 1'b0;
            if (idx_q == end_q) begin
              mux_q   <= '0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              idx_q   <= idx_q + 4'd1;
              mux_q   <= idx_q + 4'd1;
              state_q <= StSelect;
            end
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rf.MuxControlA = mux_q;
  assign rf.RegEnable   = '0;
  assign rf.out_data    = out_data_q;
  assign rf.out_index   = out_index_q;
  assign rf.out_valid   = out_valid_q;
  assign rf.busy        = busy_q;
  assign rf.done        = done_q;
`ifdef READOUT_FIB_CHECK_EN
  assign rf.chk_err     = chk_err_q;
`else
  assign rf.chk_err     = 1'b0;
`endif

endmodule

// File: tb/tb_reg_readout_fsm.sv
// Randomised self-checking bench for reg_readout_fsm against a word-list reference model.
module tb_reg_readout_fsm;
  localparam int unsigned DataW = 16;
`ifdef READOUT_FIB_CHECK_EN
  localparam bit FibEn = 1'b1;
`else
  localparam bit FibEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [DataW-1:0] regs [16];

  reg_readout_fsm_if #(.DATA_W(DataW)) rf ();
  reg_readout_fsm #(.DATA_W(DataW)) dut (.clk(clk), .reset(reset), .rf(rf));

  always #5 clk = ~clk;
  assign rf.RegData = regs[rf.MuxControlA];

  // Observations from the most recent sweep
  int         obs_idx[$];
  int         obs_dat[$];
  int         obs_err[$];
  int         acc_cyc[$];
  int         stall_dat[$];
  int         lat, done_cnt, done_gap, hold_bad, mux_bad, err_at_start;
  bit         timeout;

  task automatic preload_fib();
    int a = 1, b = 2;
    regs[0] = 16'd1;
    regs[1] = 16'd2;
    for (int i = 2; i < 16; i++) begin
      regs[i] = 16'(a + b);
      a = b;
      b = a + b - a + (a - a) + int'(regs[i]) - b;  // b becomes regs[i]
    end
  endtask

  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input int rmode,
                           input bit inject);
    int cyc = 0, stall_left = 5, last_acc = -1, done_cyc = -1;
    logic pv = 1'b0, prdy = 1'b1, rdy;
    logic [DataW-1:0] pdat = '0;
    logic [3:0] pidx = '0;
    obs_idx.delete(); obs_dat.delete(); obs_err.delete(); acc_cyc.delete(); stall_dat.delete();
    lat = -1; done_cnt = 0; hold_bad = 0; mux_bad = 0; timeout = 1'b0; err_at_start = 0;
    rf.first_reg = f;
    rf.last_reg  = l;
    rf.start     = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      rf.start = 1'b0;
      if (cyc == 1) err_at_start = int'(rf.chk_err);
      if (rf.RegEnable !== 16'd0) mux_bad++;
      if (rf.out_valid) begin
        if (rf.MuxControlA !== rf.out_index) mux_bad++;
        if (!rf.busy || rf.done) mux_bad++;
        if (lat < 0) lat = cyc;
      end else if (!rf.busy || rf.done) begin
        if (rf.MuxControlA !== 4'd0) mux_bad++;
      end
      if (pv && !prdy && (!rf.out_valid || rf.out_data !== pdat || rf.out_index !== pidx))
        hold_bad++;
      if (rf.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (cyc > 3 && !rf.busy) break;
      if (cyc > 600) begin
        timeout = 1'b1;
        break;
      end
      if (rmode == 0) rdy = 1'b1;
      else if (rmode == 1) rdy = 1'($urandom_range(0, 1));
      else if (rf.out_valid && rf.out_index == 4'd2 && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
        stall_dat.push_back(int'(rf.out_data));
      end else rdy = 1'b1;
      rf.out_ready = rdy;
      if (rf.out_valid && rdy) begin
        obs_idx.push_back(int'(rf.out_index));
        obs_dat.push_back(int'(rf.out_data));
        obs_err.push_back(int'(rf.chk_err));
        acc_cyc.push_back(cyc);
        last_acc = cyc;
      end
      pv = rf.out_valid; prdy = rdy; pdat = rf.out_data; pidx = rf.out_index;
      if (inject && rf.busy && !rf.done && $urandom_range(0, 3) == 0) begin
        rf.start     = 1'b1;
        rf.first_reg = 4'($urandom);
        rf.last_reg  = 4'($urandom);
      end
    end
    rf.out_ready = 1'b0;
    rf.start     = 1'b0;
    done_gap = (done_cyc >= 0 && last_acc >= 0) ? done_cyc - last_acc : -1;
  endtask

  task automatic test_reset();
    reset = 1'b1; rf.start = 1'b0; rf.first_reg = '0; rf.last_reg = '0; rf.out_ready = 1'b0;
    #1;
    tests++;
    if ({rf.MuxControlA, rf.RegEnable, rf.out_data, rf.out_index, rf.out_valid, rf.busy,
         rf.done, rf.chk_err} !== '0) begin
      fails++;
      $display("FAIL reset_values: got mux=%0d en=%h data=%0d idx=%0d v=%b busy=%b done=%b err=%b, need all 0",
               rf.MuxControlA, rf.RegEnable, rf.out_data, rf.out_index, rf.out_valid, rf.busy,
               rf.done, rf.chk_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rf.out_valid, rf.busy, rf.done, rf.MuxControlA} !== '0) begin
        fails++;
        $display("FAIL idle_after_reset: got v=%b busy=%b done=%b mux=%0d, need 0",
                 rf.out_valid, rf.busy, rf.done, rf.MuxControlA);
      end
    end
  endtask

  task automatic test_sweep(input string name, input logic [3:0] f, input logic [3:0] l,
                            input int rmode, input bit inject);
    int n = ((int'(l) - int'(f) + 16) % 16) + 1;
    int exp_idx[$], exp_dat[$], exp_err[$];
    int e = 0, m;
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back((int'(f) + k) % 16);
      exp_dat.push_back(int'(regs[(int'(f) + k) % 16]));
      if (FibEn && k >= 2 && exp_dat[k] != (exp_dat[k-1] + exp_dat[k-2]) % 65536) e = 1;
      exp_err.push_back(e);
    end
    run_sweep(f, l, rmode, inject);
    tests++;
    if (timeout) begin
      fails++;
      $display("FAIL %s timeout: sweep still busy after 600 cycles, need completion", name);
    end
    tests++;
    if (obs_idx.size() != n) begin
      fails++;
      $display("FAIL %s word_count: got %0d, need %0d", name, obs_idx.size(), n);
    end
    m = (obs_idx.size() < n) ? obs_idx.size() : n;
    for (int k = 0; k < m; k++) begin
      tests++;
      if (obs_idx[k] != exp_idx[k] || obs_dat[k] != exp_dat[k] || obs_err[k] != exp_err[k]) begin
        fails++;
        $display("FAIL %s word%0d: got idx=%0d data=%0d err=%0d, need idx=%0d data=%0d err=%0d",
                 name, k, obs_idx[k], obs_dat[k], obs_err[k], exp_idx[k], exp_dat[k], exp_err[k]);
      end
      if (rmode == 0) begin
        tests++;
        if (acc_cyc[k] != 3 + 3 * k) begin
          fails++;
          $display("FAIL %s accept_cycle%0d: got %0d, need %0d", name, k, acc_cyc[k], 3 + 3 * k);
        end
      end
    end
    tests++;
    if (lat != 3) begin
      fails++;
      $display("FAIL %s latency: got %0d, need 3", name, lat);
    end
    tests++;
    if (done_cnt != 1 || done_gap != 1) begin
      fails++;
      $display("FAIL %s done_pulse: got count=%0d gap=%0d, need count=1 gap=1",
               name, done_cnt, done_gap);
    end
    tests++;
    if (hold_bad != 0 || mux_bad != 0 || err_at_start != 0) begin
      fails++;
      $display("FAIL %s invariants: got hold_bad=%0d mux_bad=%0d err_at_start=%0d, need 0/0/0",
               name, hold_bad, mux_bad, err_at_start);
    end
    if (rmode == 2) begin
      tests++;
      if (stall_dat.size() != 5) begin
        fails++;
        $display("FAIL %s stall_len: got %0d, need 5", name, stall_dat.size());
      end
      foreach (stall_dat[k]) begin
        tests++;
        if (stall_dat[k] != int'(regs[2])) begin
          fails++;
          $display("FAIL %s stall_data%0d: got %0d, need %0d", name, k, stall_dat[k], regs[2]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
    test_sweep("b2b_a", 4'd3, 4'd8, 0, 1'b0);
    test_sweep("b2b_b", 4'd12, 4'd2, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 16; i++) regs[i] = 16'($urandom);
      test_sweep("random", 4'($urandom), 4'($urandom), 1, 1'b1);
    end
  endtask

  task automatic test_fib_check();
    preload_fib();
    regs[5] = 16'd14;
    test_sweep("fib_bad", 4'd0, 4'd15, 0, 1'b0);
    repeat (2) @(negedge clk);
    tests++;
    if (rf.chk_err !== FibEn) begin
      fails++;
      $display("FAIL fib_sticky: got chk_err=%b, need %b", rf.chk_err, FibEn);
    end
    preload_fib();
    test_sweep("fib_clear", 4'd0, 4'd3, 0, 1'b0);
  endtask

  task automatic test_reset_mid_sweep();
    bit found = 1'b0;
    preload_fib();
    rf.first_reg = 4'd0; rf.last_reg = 4'd15; rf.out_ready = 1'b1; rf.start = 1'b1;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      rf.start = 1'b0;
      if (rf.out_valid && rf.out_index == 4'd4) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL midreset_reach: got no word at index 4 in 100 cycles, need one");
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({rf.out_valid, rf.busy, rf.MuxControlA, rf.done} !== '0) begin
      fails++;
      $display("FAIL midreset_async: got v=%b busy=%b mux=%0d done=%b, need all 0",
               rf.out_valid, rf.busy, rf.MuxControlA, rf.done);
    end
    rf.out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if ({rf.out_valid, rf.busy, rf.done, rf.out_index, rf.out_data} !== '0) begin
        fails++;
        $display("FAIL midreset_quiet: got v=%b busy=%b done=%b idx=%0d data=%0d, need 0",
                 rf.out_valid, rf.busy, rf.done, rf.out_index, rf.out_data);
      end
    end
    test_sweep("after_reset", 4'd9, 4'd11, 0, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = '0;
    test_reset();
    preload_fib();
    test_sweep("full_sweep", 4'd0, 4'd15, 0, 1'b0);
    test_sweep("stall", 4'd0, 4'd15, 2, 1'b0);
    test_sweep("wrap", 4'd14, 4'd1, 0, 1'b0);
    test_sweep("single", 4'd7, 4'd7, 0, 1'b0);
    test_sweep("busy_start", 4'd2, 4'd9, 0, 1'b1);
    test_back_to_back();
    test_random();
    test_fib_check();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running at 2 ms, need completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_readout_fsm.md
REG_READOUT_FSM -- requirements
Module: reg_readout_fsm

Interface
REQ-001 Parameter: DATA_W, 16, width of register-file word and output data.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to begin a readout sweep; sampled only in IDLE.
REQ-005 first_reg  input  4  index of first register to read; sampled with start.
REQ-006 last_reg  input  4  index of last register to read; sampled with start.
REQ-007 RegData  input  DATA_W  register-file word selected by MuxControlA, combinational from datapath.
REQ-008 out_ready  input  1  downstream consumer accepts out_data when high with out_valid.
REQ-009 MuxControlA  output  4  register select driven to datapath mux A.
REQ-010 RegEnable  output  16  register write enables; SHALL be all-zero at all times (reader never writes).
REQ-011 out_data  output  DATA_W  captured register word.
REQ-012 out_index  output  4  register index of out_data.
REQ-013 out_valid  output  1  out_data/out_index valid.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle pulse after last word accepted.
REQ-016 chk_err  output  1  sticky sequence-check error flag.

Function
REQ-017 States SHALL be IDLE, SELECT, CAPTURE, PRESENT, DONE.
REQ-018 IDLE: on start=1 latch first_reg into idx, last_reg into end, clear chk_err, go SELECT; otherwise remain.
REQ-019 SELECT: drive MuxControlA=idx for one settling cycle, go CAPTURE.
REQ-020 CAPTURE: register RegData into out_data and idx into out_index, go PRESENT.
REQ-021 PRESENT: out_valid=1; out_data/out_index SHALL hold stable while out_ready=0.
REQ-022 PRESENT with out_ready=1: if idx==end go DONE, else idx<=idx+1 (mod 16) and go SELECT.
REQ-023 DONE: done=1 for exactly one cycle, busy=1, go IDLE.
REQ-024 MuxControlA SHALL equal idx in SELECT, CAPTURE and PRESENT, and 0 in IDLE and DONE.
REQ-025 Latency: start to first out_valid SHALL be 3 cycles; back-to-back words with out_ready=1 every 3 cycles.
REQ-026 Wrap-around: if last_reg<first_reg, sweep SHALL run first_reg..15 then 0..last_reg; word count=((last_reg-first_reg) mod 16)+1.
REQ-027 first_reg==last_reg SHALL produce exactly one word.
REQ-028 start asserted while busy SHALL be ignored; no effect on the sweep in progress.
REQ-029 out_valid SHALL never assert outside PRESENT.

Reset
REQ-030 reset=1 SHALL force IDLE immediately regardless of clk, including mid-sweep.
REQ-031 Reset values: MuxControlA=0, RegEnable=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0, chk_err=0, idx=0, end=0.
REQ-032 After reset release, no output activity until a new start.

Configuration
REQ-033 Macro READOUT_FIB_CHECK_EN: when defined, block keeps the previous two captured words; for the third and later words of a sweep, if captured word != (prev1+prev2) mod 2^DATA_W, chk_err SHALL set on the cycle after CAPTURE and stay set until next accepted start or reset.
REQ-034 Without READOUT_FIB_CHECK_EN, chk_err SHALL be constant 0 and no history registers are built.

Verification
REQ-035 r0..r15 preloaded 1,2,3,5,...,1597; start, first=0, last=15, out_ready=1 -> 16 words 1..1597 with out_index 0..15, single done pulse, chk_err=0.
REQ-036 Same preload, out_ready=0 for 5 cycles while out_index=2 -> out_data held at 3 for all 5 cycles, no word lost or duplicated.
REQ-037 first=14, last=1 -> out_index sequence 14,15,0,1 with data 987,1597,1,2; done after 4th accept.
REQ-038 first=last=7 -> exactly one word 34, out_index 7, done one cycle after accept.
REQ-039 reset pulsed asynchronously while out_index=4 in PRESENT -> out_valid, busy, MuxControlA drop to 0 without clock edge; next start sweeps cleanly from new first_reg.
REQ-040 With READOUT_FIB_CHECK_EN, r5 preloaded 14 instead of 13, sweep 0..15 -> chk_err rises after r5 capture, stays 1 to sweep end, clears on next start; without macro chk_err stays 0.
